mdu: RTL
========

# mdu

Multiply/divide unit for the pipelined CPU. It sits in the EX stage directly downstream of the forwarding multiplexers: it takes the two forwarded 32-bit operands, runs multi-cycle multiply/divide operations, and holds the architectural HI/LO registers. Its `busy` output feeds the hazard unit, which stalls any MD-class instruction in ID. HI/LO feed the EX result-select multiplexer for mfhi/mflo.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration of mult/multu, in cycles (must be ≥1).
- `DIV_CYCLES`, 10: busy duration of div/divu, in cycles (must be ≥1).

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input 1: op valid this cycle. EX asserts it for one cycle per instruction.
- `op` input 3: operation select.
  - 0: none
  - 1: MULT
  - 2: MULTU
  - 3: DIV
  - 4: DIVU
  - 5: MTHI
  - 6: MTLO
  - 7: none
- `A` input 32: forwarded rs operand.
- `B` input 32: forwarded rt operand.
- `busy` output 1: a multiply/divide is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
State: IDLE / BUSY. Internal state:
- counter, 4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES).
- pend_hi / pend_lo: pending 32-bit result.

Reset:
- `HI` = 0, `LO` = 0, `busy` = 0.
- State = IDLE, counter = 0, pending = 0.
- Reset overrides every other input on the same edge.

Behaviour in IDLE, on an edge with `start`=1:
- MULT: {pend_hi, pend_lo} = signed(A)×signed(B), a 64-bit product. Counter = MULT_CYCLES. Go to BUSY.
- MULTU: same as MULT, with unsigned operands.
- DIV (signed):
  - pend_lo = quotient, truncated toward zero.
  - pend_hi = remainder; its sign follows A.
  - Special case A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - Counter = DIV_CYCLES. Go to BUSY.
- DIVU: unsigned quotient/remainder. Counter = DIV_CYCLES. Go to BUSY.
- Divide by zero (DIV or DIVU with B=0):
  - Enters BUSY for DIV_CYCLES as normal.
  - HI/LO are left unchanged at completion (a no-write flag is latched).
- MTHI: `HI` ← A on this edge. Stay IDLE.
- MTLO: `LO` ← A on this edge. Stay IDLE.
- op 0 or 7: no effect.

Behaviour in BUSY:
- Counter decrements each edge.
- On the edge where counter goes 1→0:
  - `HI` ← pend_hi and `LO` ← pend_lo, unless the no-write flag is set.
  - State → IDLE.
- `start` is ignored in BUSY, including MTHI/MTLO. The hazard unit guarantees it is never asserted then. Ignoring it is the required defined behaviour.

Operand capture:
- A/B are used only on the start edge; later changes to A/B have no effect.
- Results may be computed combinationally at start and held in pending. An iterative datapath is also acceptable, provided the result and timing are identical.

## Timing
- `busy` is a registered output, equal to (state == BUSY).
- Start sampled at edge E0:
  - `busy` = 1 from just after E0 through edge E_N, where N = MULT_CYCLES or DIV_CYCLES. `busy` is high for exactly N cycles.
  - HI/LO take the new value just after E_N, the same edge `busy` falls.
- Back-to-back operations: `start` may be accepted on edge E_N+1, the first edge with `busy`=0. There is no dead cycle.
- A start in the cycle when `busy`=1 is dropped, even if that cycle's edge is E_N.
- MTHI/MTLO have 1-edge latency. HI/LO are visible in the following cycle.
- HI/LO stay stable throughout BUSY; they show the old values until E_N.
- Reset during BUSY:
  - Aborts the operation; no write occurs.
  - `busy` = 0 and HI = LO = 0 after the reset edge.

## Test plan
- Reset, then MULT with A=0xFFFFFFFE (−2), B=3:
  - `busy` is high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
  - HI/LO stay 0 while busy.
- MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF:
  - HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
  - A second MULTU started on the first edge with `busy`=0 is accepted with no gap.
- DIV with A=0xFFFFFFF9 (−7), B=2:
  - After 10 cycles, LO=0xFFFFFFFD (−3) and HI=0xFFFFFFFF (−1).
- DIV with A=0x80000000, B=0xFFFFFFFF:
  - LO=0x80000000, HI=0.
- DIVU with B=0, after MTHI A=0x11 and MTLO A=0x22:
  - `busy` is high for 10 cycles.
  - HI=0x11 and LO=0x22 are unchanged afterward.
- DIVU with A=100, B=7; pulse `start` with MTHI A=0xDEAD mid-busy; assert `reset` at busy cycle 4 of a rerun:
  - First run ends with LO=14 and HI=2; the MTHI is ignored.
  - Rerun: `busy` drops after the reset edge and HI=LO=0, with no late write.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle mult/div with architectural HI/LO registers.
// Results are computed at start, held in a pending register, and committed after a fixed latency.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi, pend_lo;
    logic          nowrite;

    logic [63:0] prod;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, b_safe, quo_mag, rem_mag, quo, rem;

    // Handshake: start is a one-cycle valid; an op is accepted only on an edge
    // where busy is low. Starts seen while busy are dropped, never queued.
    assign busy = (state == BUSY);

    // Signed divide works on magnitudes so that 0x80000000 / -1 needs no special path.
    always_comb begin
        prod = 64'd0;
        if (op == OP_MULT)
            prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        else
            prod = {32'd0, A} * {32'd0, B};
        div_signed = (op == OP_DIV);
        a_mag   = (div_signed && A[31]) ? (32'd0 - A) : A;
        b_mag   = (div_signed && B[31]) ? (32'd0 - B) : B;
        b_safe  = (B == 32'd0) ? 32'd1 : b_mag;
        quo_mag = a_mag / b_safe;
        rem_mag = a_mag % b_safe;
        quo     = (div_signed && (A[31] ^ B[31])) ? (32'd0 - quo_mag) : quo_mag;
        rem     = (div_signed && A[31]) ? (32'd0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU))
                      state_n = BUSY;
            BUSY: if (cnt == CW'(1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            nowrite <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state <= state_n;
            if (state == IDLE) begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            {pend_hi, pend_lo} <= prod;
                            cnt     <= CW'(MULT_CYCLES);
                            nowrite <= 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi <= rem;
                            pend_lo <= quo;
                            cnt     <= CW'(DIV_CYCLES);
                            nowrite <= (B == 32'd0);
                        end
                        OP_MTHI: HI <= A;
                        OP_MTLO: LO <= A;
                        default: ;
                    endcase
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1) && !nowrite) begin
                    HI <= pend_hi;
                    LO <= pend_lo;
                end
            end
        end
    end

endmodule
